// File: rtl/pc_gen.sv
// pc_gen -- program counter generator for an in-order fetch front end.
//
// Produces the fetch address pc_o with a valid/ready handshake towards the
// fetch stage. The next PC is chosen in priority order: trap redirect, branch
// redirect, return-stack pop, sequential increment on accept, then hold.
// A small BOOT/RUN/HALT state machine gates pc_valid_o and supports a
// handshake-aligned halt and a resume.
//
// Optional feature: define the macro PC_GEN_RAS_EN to build a return address
// stack (RAS) of RAS_DEPTH entries. Without it the block has no stack storage,
// call_i/ret_i are ignored and ras_empty_o is tied high.
//
// Reset is asynchronous and active-high on rst. All state updates on the
// rising edge of clk.

module pc_gen #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       INC       = 4,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_ready_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              trap_flag_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              halt_i,
  input  logic              resume_i,
  input  logic              call_i,
  input  logic              ret_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              halted_o,
  output logic              ras_empty_o
);

  // INC is a power of two, so redirect targets are aligned by clearing the
  // low log2(INC) bits.
  localparam int unsigned       ALIGN_W    = $clog2(INC);
  localparam logic [ADDR_W-1:0] INC_VAL    = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_W;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic              pc_valid_reg;
  logic              halted_reg;
  logic              halt_pend_reg;

  logic              accept;
  logic              redirect;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] trap_target;
  logic [ADDR_W-1:0] branch_target;

  // Return-stack interface towards the next-PC mux.
  logic              ras_ret_take;
  logic [ADDR_W-1:0] ras_ret_addr;
  logic              ras_empty;

  assign accept        = pc_valid_reg & fetch_ready_i;
  assign redirect      = trap_flag_i | branch_flag_i;
  assign pc_inc        = pc_reg + INC_VAL;  // wraps modulo 2^ADDR_W
  assign trap_target   = trap_addr_i & ALIGN_MASK;
  assign branch_target = branch_addr_i & ALIGN_MASK;

`ifdef PC_GEN_RAS_EN
  // ---------------------------------------------------------------------
  // Return address stack: circular buffer addressed by a stack pointer that
  // points at the next free slot. A push when full simply wraps and
  // overwrites the oldest entry; the count saturates at RAS_DEPTH.
  // ---------------------------------------------------------------------
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] RAS_FULL = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_sp_reg;
  logic [PTR_W:0]    ras_cnt_reg;
  logic [PTR_W-1:0]  ras_top_idx;
  logic [PTR_W-1:0]  ras_wr_idx;
  logic              ras_push;
  logic              ras_pop;

  assign ras_empty   = (ras_cnt_reg == '0);
  assign ras_top_idx = ras_sp_reg - 1'b1;

  // Stack operations only happen for an accepted instruction that is not
  // overridden by a redirect; a redirect wins the next PC, so its call/ret
  // must not disturb the stack either.
  assign ras_push = accept & call_i & ~redirect;
  assign ras_pop  = accept & ret_i & ~redirect & ~ras_empty;

  // A simultaneous call+ret replaces the top entry in place.
  assign ras_wr_idx   = ras_pop ? ras_top_idx : ras_sp_reg;
  assign ras_ret_take = ras_pop;
  assign ras_ret_addr = ras_mem[ras_top_idx];

  // Stack storage: contents need no reset, validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem[ras_wr_idx] <= pc_inc;
    end
  end

  // Stack pointer and occupancy; a trap flushes the stack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_sp_reg  <= '0;
      ras_cnt_reg <= '0;
    end else if (trap_flag_i) begin
      ras_sp_reg  <= '0;
      ras_cnt_reg <= '0;
    end else if (ras_push && !ras_pop) begin
      ras_sp_reg <= ras_sp_reg + 1'b1;
      if (ras_cnt_reg != RAS_FULL) begin
        ras_cnt_reg <= ras_cnt_reg + 1'b1;
      end
    end else if (ras_pop && !ras_push) begin
      ras_sp_reg  <= ras_top_idx;
      ras_cnt_reg <= ras_cnt_reg - 1'b1;
    end
  end
`else
  // No return stack: call/ret have no effect and the stack always reads empty.
  logic unused_ras_inputs;
  assign unused_ras_inputs = &{1'b0, call_i, ret_i};
  assign ras_empty    = 1'b1;
  assign ras_ret_take = 1'b0;
  assign ras_ret_addr = '0;
`endif

  // Next-PC selection: trap > branch > RAS return > accept increment > hold.
  always_comb begin
    pc_next = pc_reg;
    if (trap_flag_i) begin
      pc_next = trap_target;
    end else if (branch_flag_i) begin
      pc_next = branch_target;
    end else if (ras_ret_take) begin
      pc_next = ras_ret_addr;
    end else if (accept) begin
      pc_next = pc_inc;
    end
  end

  // Control FSM with registered outputs; the PC register updates every cycle
  // from the next-PC mux, so redirects apply in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_BOOT;
      pc_reg        <= RESET_VEC;
      pc_valid_reg  <= 1'b0;
      halted_reg    <= 1'b0;
      halt_pend_reg <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      case (state_reg)
        ST_BOOT: begin
          // BOOT always lasts one cycle; a halt requested here is remembered
          // and taken on the first accepted fetch.
          state_reg     <= ST_RUN;
          pc_valid_reg  <= 1'b1;
          halted_reg    <= 1'b0;
          halt_pend_reg <= halt_i;
        end
        ST_RUN: begin
          if (accept && (halt_i || halt_pend_reg)) begin
            // The current request completes its handshake, then we stop.
            state_reg     <= ST_HALT;
            pc_valid_reg  <= 1'b0;
            halted_reg    <= 1'b1;
            halt_pend_reg <= 1'b0;
          end else if (halt_i) begin
            halt_pend_reg <= 1'b1;
          end
        end
        ST_HALT: begin
          // A concurrent halt request keeps us halted.
          if (resume_i && !halt_i) begin
            state_reg    <= ST_RUN;
            pc_valid_reg <= 1'b1;
            halted_reg   <= 1'b0;
          end
          halt_pend_reg <= 1'b0;
        end
        default: begin
          state_reg     <= ST_BOOT;
          pc_valid_reg  <= 1'b0;
          halted_reg    <= 1'b0;
          halt_pend_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o        = pc_reg;
  assign pc_valid_o  = pc_valid_reg;
  assign halted_o    = halted_reg;
  assign ras_empty_o = ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- directed scoreboard bench for pc_gen at default parameters.
// The stimulus process drives one cycle at a time and queues the expected
// post-edge outputs; a monitor on the falling edge pops and compares them.
// Return-stack vectors run when PC_GEN_RAS_EN is defined; otherwise the bench
// checks that call/ret are ignored and the stack reads empty.

module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready_i;
  logic        branch_flag_i;
  logic [31:0] branch_addr_i;
  logic        trap_flag_i;
  logic [31:0] trap_addr_i;
  logic        halt_i;
  logic        resume_i;
  logic        call_i;
  logic        ret_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        halted_o;
  logic        ras_empty_o;

  typedef struct {
    string       name;
    logic [31:0] pc;
    bit          v;
    bit          h;
    bit          e;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] tail_pc;
  bit          tail_e;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_ready_i (fetch_ready_i),
    .branch_flag_i (branch_flag_i),
    .branch_addr_i (branch_addr_i),
    .trap_flag_i   (trap_flag_i),
    .trap_addr_i   (trap_addr_i),
    .halt_i        (halt_i),
    .resume_i      (resume_i),
    .call_i        (call_i),
    .ret_i         (ret_i),
    .pc_o          (pc_o),
    .pc_valid_o    (pc_valid_o),
    .halted_o      (halted_o),
    .ras_empty_o   (ras_empty_o)
  );

  // Monitor: compare every queued expectation half a cycle after its edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks += 4;
      if (pc_o !== mon_e.pc) begin
        errors++;
        $display("FAIL %s pc_o: got %h expected %h", mon_e.name, pc_o, mon_e.pc);
      end
      if (pc_valid_o !== mon_e.v) begin
        errors++;
        $display("FAIL %s pc_valid_o: got %b expected %b", mon_e.name, pc_valid_o, mon_e.v);
      end
      if (halted_o !== mon_e.h) begin
        errors++;
        $display("FAIL %s halted_o: got %b expected %b", mon_e.name, halted_o, mon_e.h);
      end
      if (ras_empty_o !== mon_e.e) begin
        errors++;
        $display("FAIL %s ras_empty_o: got %b expected %b", mon_e.name, ras_empty_o, mon_e.e);
      end
      $display("txn %-12s pc_o=%h valid=%0b halted=%0b empty=%0b",
               mon_e.name, pc_o, pc_valid_o, halted_o, ras_empty_o);
    end
  end

  task automatic drv(input bit fr, input bit br, input logic [31:0] ba,
                     input bit tr, input logic [31:0] ta, input bit ha,
                     input bit rs, input bit ca, input bit rt);
    fetch_ready_i = fr;
    branch_flag_i = br;
    branch_addr_i = ba;
    trap_flag_i   = tr;
    trap_addr_i   = ta;
    halt_i        = ha;
    resume_i      = rs;
    call_i        = ca;
    ret_i         = rt;
  endtask

  // One clock: inputs already driven; queue the expected post-edge outputs.
  task automatic cyc(input string nm, input logic [31:0] pc,
                     input bit v, input bit h, input bit e);
    exp_t x;
    @(posedge clk);
    #1;
    x.name = nm;
    x.pc   = pc;
    x.v    = v;
    x.h    = h;
    x.e    = e;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drv(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    cyc("reset", 32'h0, 0, 0, 1);
    rst = 1'b0;

    // Boot and sequential fetch.
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    cyc("boot_exit", 32'h0, 1, 0, 1);
    cyc("seq_4", 32'h4, 1, 0, 1);
    cyc("seq_8", 32'h8, 1, 0, 1);
    cyc("seq_c", 32'hC, 1, 0, 1);
    cyc("seq_10", 32'h10, 1, 0, 1);

    // Stall holds, branch during stall redirects with alignment.
    drv(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("stall", 32'h10, 1, 0, 1);
    drv(0, 1, 32'h103, 0, 32'h0, 0, 0, 0, 0);
    cyc("br_stall", 32'h100, 1, 0, 1);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    cyc("after_br", 32'h104, 1, 0, 1);

    // Trap beats branch.
    drv(1, 1, 32'h200, 1, 32'h80, 0, 0, 0, 0);
    cyc("trap_pri", 32'h80, 1, 0, 1);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    cyc("after_trap", 32'h84, 1, 0, 1);

    // Wrap at the top of the address space.
    drv(1, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0, 0, 0);
    cyc("br_top", 32'hFFFF_FFFC, 1, 0, 1);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    cyc("wrap", 32'h0, 1, 0, 1);

    // Halt waits for accept, freezes pc, both-high stays halted, resume.
    drv(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0);
    cyc("halt_wait", 32'h0, 1, 0, 1);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    cyc("halt_enter", 32'h4, 0, 1, 1);
    cyc("halt_frz1", 32'h4, 0, 1, 1);
    cyc("halt_frz2", 32'h4, 0, 1, 1);
    drv(1, 0, 32'h0, 0, 32'h0, 1, 1, 0, 0);
    cyc("halt_both", 32'h4, 0, 1, 1);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0);
    cyc("resume", 32'h4, 1, 0, 1);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    cyc("run_8", 32'h8, 1, 0, 1);
    drv(0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0);
    cyc("rs_ignored", 32'h8, 1, 0, 1);

    // Halt with same-cycle branch; branch while halted.
    drv(1, 1, 32'h500, 0, 32'h0, 1, 0, 0, 0);
    cyc("halt_br", 32'h500, 0, 1, 1);
    drv(1, 1, 32'h606, 0, 32'h0, 0, 0, 0, 0);
    cyc("br_halt", 32'h604, 0, 1, 1);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0);
    cyc("resume2", 32'h604, 1, 0, 1);

`ifdef PC_GEN_RAS_EN
    drv(1, 1, 32'h40, 0, 32'h0, 0, 0, 0, 0);
    cyc("br_40", 32'h40, 1, 0, 1);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0);
    cyc("call_40", 32'h44, 1, 0, 0);
    drv(1, 1, 32'h300, 0, 32'h0, 0, 0, 0, 0);
    cyc("br_300", 32'h300, 1, 0, 0);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
    cyc("ret_300", 32'h44, 1, 0, 1);

    // Five calls into a four-entry stack, then five returns.
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0);
    cyc("call_1", 32'h48, 1, 0, 0);
    cyc("call_2", 32'h4C, 1, 0, 0);
    cyc("call_3", 32'h50, 1, 0, 0);
    cyc("call_4", 32'h54, 1, 0, 0);
    cyc("call_5", 32'h58, 1, 0, 0);
    drv(1, 1, 32'h700, 0, 32'h0, 0, 0, 0, 0);
    cyc("br_700", 32'h700, 1, 0, 0);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
    cyc("ret_1", 32'h58, 1, 0, 0);
    cyc("ret_2", 32'h54, 1, 0, 0);
    cyc("ret_3", 32'h50, 1, 0, 0);
    cyc("ret_4", 32'h4C, 1, 0, 1);
    cyc("ret_5_inc", 32'h50, 1, 0, 1);

    // Call and ret together swap the top entry.
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0);
    cyc("call_50", 32'h54, 1, 0, 0);
    drv(1, 1, 32'h800, 0, 32'h0, 0, 0, 0, 0);
    cyc("br_800", 32'h800, 1, 0, 0);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 1);
    cyc("call_ret", 32'h54, 1, 0, 0);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
    cyc("ret_swap", 32'h804, 1, 0, 1);

    // Trap flushes the stack.
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0);
    cyc("call_804", 32'h808, 1, 0, 0);
    drv(1, 0, 32'h0, 1, 32'h90, 0, 0, 0, 0);
    cyc("trap_clr", 32'h90, 1, 0, 1);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
    cyc("ret_empty", 32'h94, 1, 0, 1);

    // Ret without accept ignored; branch leaves the stack intact.
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0);
    cyc("call_94", 32'h98, 1, 0, 0);
    drv(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
    cyc("ret_stall", 32'h98, 1, 0, 0);
    drv(1, 1, 32'h120, 0, 32'h0, 0, 0, 0, 0);
    cyc("br_keep", 32'h120, 1, 0, 0);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
    cyc("ret_120", 32'h98, 1, 0, 1);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0);
    cyc("call_98", 32'h9C, 1, 0, 0);
    tail_pc = 32'h9C;
    tail_e  = 1'b0;
`else
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0);
    cyc("call_ign", 32'h608, 1, 0, 1);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
    cyc("ret_ign", 32'h60C, 1, 0, 1);
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 1);
    cyc("callret_ign", 32'h610, 1, 0, 1);
    tail_pc = 32'h610;
    tail_e  = 1'b1;
`endif

    // Reset mid-operation discards a pending halt and the stack.
    drv(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0);
    cyc("halt_pend", tail_pc, 1, 0, tail_e);
    rst = 1'b1;
    drv(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    cyc("rst_mid", 32'h0, 0, 0, 1);
    rst = 1'b0;
    drv(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    cyc("boot2", 32'h0, 1, 0, 1);
    cyc("no_halt_4", 32'h4, 1, 0, 1);
    cyc("no_halt_8", 32'h8, 1, 0, 1);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 0, PC loaded by reset.
REQ-003 SHALL have parameter INC, default 4, sequential increment; power of two, 2..8.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-stack entries; power of two, 2..16.
REQ-005 SHALL use one clock; reset is asynchronous and active-high; ports clk and rst.
REQ-006 clk  input  1  clock, all state updates on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 fetch_ready_i  input  1  fetch stage accepts current pc_o.
REQ-009 branch_flag_i  input  1  branch redirect request.
REQ-010 branch_addr_i  input  ADDR_W  branch target.
REQ-011 trap_flag_i  input  1  trap/exception redirect request.
REQ-012 trap_addr_i  input  ADDR_W  trap vector.
REQ-013 halt_i  input  1  request halt after current handshake.
REQ-014 resume_i  input  1  leave HALT.
REQ-015 call_i  input  1  instruction at pc_o is a call.
REQ-016 ret_i  input  1  instruction at pc_o is a return.
REQ-017 pc_o  output  ADDR_W  current fetch address.
REQ-018 pc_valid_o  output  1  pc_o is a valid fetch request.
REQ-019 halted_o  output  1  block is in HALT.
REQ-020 ras_empty_o  output  1  return stack holds no entries.

Function
REQ-021 SHALL implement states BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-022 pc_valid_o SHALL be 1 only in RUN; halted_o SHALL be 1 only in HALT.
REQ-023 Accept SHALL mean pc_valid_o & fetch_ready_i in the same cycle.
REQ-024 Next-PC priority SHALL be: trap_flag_i > branch_flag_i > RAS return > accept increment > hold.
REQ-025 Trap and branch SHALL update pc_o next cycle in any state, whether or not accepted; the stalled request is discarded.
REQ-026 Redirect targets SHALL have low log2(INC) bits forced to zero.
REQ-027 On accept without redirect, pc_o SHALL become pc_o + INC, modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000 at defaults).
REQ-028 Without accept or redirect, pc_o SHALL hold; no increment while stalled or halted.
REQ-029 halt_i in RUN SHALL enter HALT on the next accept, or immediately on the next edge if pc_valid_o is 0; a same-cycle redirect is still applied.
REQ-030 resume_i in HALT SHALL return to RUN next cycle with pc_o unchanged; resume_i outside HALT SHALL be ignored.
REQ-031 halt_i and resume_i both high in HALT SHALL stay in HALT.

Reset
REQ-032 Reset SHALL asynchronously set pc_o=RESET_VEC, state=BOOT, pc_valid_o=0, halted_o=0, RAS empty (ras_empty_o=1).
REQ-033 Reset asserted mid-operation SHALL discard any pending redirect, halt request or RAS contents.

Configuration
REQ-034 Macro PC_GEN_RAS_EN defined: call_i on accept SHALL push pc_o+INC; ret_i on accept with non-empty stack SHALL load top-of-stack into pc_o and pop.
REQ-035 With PC_GEN_RAS_EN: push when full SHALL overwrite the oldest entry; ret_i when empty SHALL fall back to sequential increment; call_i and ret_i together SHALL replace top with pc_o+INC and jump to the old top.
REQ-036 With PC_GEN_RAS_EN: trap_flag_i SHALL clear the stack; branch_flag_i SHALL not touch it; call_i/ret_i without accept SHALL be ignored.
REQ-037 Macro PC_GEN_RAS_EN undefined: no stack storage; call_i/ret_i ignored; ras_empty_o tied 1.

Verification
REQ-038 Reset, release, fetch_ready_i=1 -> pc_valid_o=0 one cycle, then pc_o 0x0, 0x4, 0x8 on successive cycles.
REQ-039 fetch_ready_i=0 for 3 cycles at pc_o=0x10 -> pc_o holds 0x10; branch_flag_i with target 0x103 during stall -> pc_o=0x100 next cycle.
REQ-040 trap_flag_i (0x80) and branch_flag_i (0x200) in the same cycle -> pc_o=0x80.
REQ-041 pc_o=0xFFFFFFFC accepted -> pc_o=0x00000000; halt_i -> halted_o=1, pc_o frozen; resume_i -> RUN, same pc_o.
REQ-042 PC_GEN_RAS_EN: call at 0x40 then branch to 0x300, ret at 0x300 accepted -> pc_o=0x44, ras_empty_o=1; five calls with RAS_DEPTH=4 then five rets -> four popped targets, fifth ret increments.
